// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Operand forwarding for NUM_RPORTS read ports from NUM_STAGES x NUM_LANES
//   in-flight writer slots, combined with a registered scoreboard that tracks
//   outstanding long-latency producers (mul/div/cache-miss load).
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   fwd_en/addr/data   writer slot k = s*NUM_LANES + l (stage 0 = youngest)
//   fwd_vld            slot result available this cycle (0 = load pending)
//   rd_addr, rf_data   per read port source register and regfile data
//   rd_data, rd_stall  forwarded operand and operand-not-ready per port
//   li_valid/addr      long-latency issue request and its destination
//   li_ready           issue accepted when li_valid && li_ready
//   ld_en/addr/data    long-latency completion (bypassed in the same cycle)
//   pend_cnt           number of outstanding long-latency ops
//   sb_err             sticky flag: completion for a register not pending
module fwd_scoreboard #(
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned NUM_RPORTS = 4,
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned MAX_PEND   = 4
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [NUM_STAGES*NUM_LANES-1:0]       fwd_en,
  input  logic [NUM_STAGES*NUM_LANES*AW-1:0]    fwd_addr,
  input  logic [NUM_STAGES*NUM_LANES*DW-1:0]    fwd_data,
  input  logic [NUM_STAGES*NUM_LANES-1:0]       fwd_vld,
  input  logic [NUM_RPORTS*AW-1:0]              rd_addr,
  input  logic [NUM_RPORTS*DW-1:0]              rf_data,
  output logic [NUM_RPORTS*DW-1:0]              rd_data,
  output logic [NUM_RPORTS-1:0]                 rd_stall,
  input  logic                                  li_valid,
  input  logic [AW-1:0]                         li_addr,
  output logic                                  li_ready,
  input  logic                                  ld_en,
  input  logic [AW-1:0]                         ld_addr,
  input  logic [DW-1:0]                         ld_data,
  output logic [$clog2(MAX_PEND+1)-1:0]         pend_cnt,
  output logic                                  sb_err
);

  localparam int unsigned NREG = 2**AW;
  localparam int unsigned CW   = $clog2(MAX_PEND+1);

  // Bit 0 exists only so the vector can be indexed directly by a register
  // address; it is never set because issues to r0 are dropped.
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic [CW-1:0]   cnt_d;
  logic            issue_acc;
  logic            ld_hit;
  logic            ld_bad;

  // ---------------------------------------------------------------------------
  // Scoreboard control
  // ---------------------------------------------------------------------------
  // No bypass from a same-cycle completion: li_ready depends on state only.
  assign li_ready  = (pend_cnt < CW'(MAX_PEND)) && !pending_q[li_addr];
  assign issue_acc = li_valid && li_ready && (li_addr != '0);
  // pending_q[0] is always 0, so a completion to r0 lands in ld_bad.
  assign ld_hit    = ld_en &&  pending_q[ld_addr];
  assign ld_bad    = ld_en && !pending_q[ld_addr];

  // An accepted issue targets a non-pending register and a completion hit
  // targets a pending one, so the two never touch the same bit.
  always_comb begin
    pending_d = pending_q;
    cnt_d     = pend_cnt;
    if (issue_acc) pending_d[li_addr] = 1'b1;
    if (ld_hit)    pending_d[ld_addr] = 1'b0;
    case ({issue_acc, ld_hit})
      2'b10:   cnt_d = pend_cnt + CW'(1);
      2'b01:   cnt_d = pend_cnt - CW'(1);
      default: cnt_d = pend_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q <= '0;
      pend_cnt  <= '0;
      sb_err    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      pend_cnt  <= cnt_d;
      if (ld_bad) sb_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port forwarding
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < NUM_RPORTS; r++) begin : g_port
    logic [AW-1:0] ra;
    logic [DW-1:0] rf;
    logic          hit;
    logic [DW-1:0] hit_data;
    logic          hit_stall;
    logic [DW-1:0] port_data;
    logic          port_stall;

    assign ra = rd_addr[r*AW +: AW];
    assign rf = rf_data[r*DW +: DW];

    // Youngest stage first; within a stage the highest lane is the latest
    // in program order, so lanes are scanned from NUM_LANES-1 downwards.
    // Only the first hit matters, including its valid bit.
    always_comb begin
      hit       = 1'b0;
      hit_data  = '0;
      hit_stall = 1'b0;
      for (int unsigned s = 0; s < NUM_STAGES; s++) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
          if (!hit && fwd_en[s*NUM_LANES + NUM_LANES-1-i] &&
              (fwd_addr[(s*NUM_LANES + NUM_LANES-1-i)*AW +: AW] == ra)) begin
            hit       = 1'b1;
            hit_data  = fwd_data[(s*NUM_LANES + NUM_LANES-1-i)*DW +: DW];
            hit_stall = ~fwd_vld[s*NUM_LANES + NUM_LANES-1-i];
          end
        end
      end
    end

    // A completing long op outranks slot hits: WAW blocking guarantees any
    // in-flight slot writing a pending register is older than the long op.
    always_comb begin
      port_data  = rf;
      port_stall = 1'b0;
      if (ra == '0) begin
        port_data = '0;
      end else if (ld_en && (ld_addr == ra)) begin
        port_data = ld_data;
      end else if (pending_q[ra]) begin
        port_stall = 1'b1;
      end else if (hit) begin
        port_data  = hit_data;
        port_stall = hit_stall;
      end
    end

    assign rd_data[r*DW +: DW] = port_data;
    assign rd_stall[r]         = port_stall;
  end

endmodule
